instruction_fetch: RTL and testbench

Fetch stage of the SimpleRisc core: holds the program counter, issues word reads to instruction memory, and presents one fetched instruction at a time to the instruction decoder through a valid/ready handshake. It sits directly upstream of the decoder. It accepts PC redirects from the branch/return logic (b, beq, bgt, call, ret). Memory responses that are in flight when a redirect arrives are discarded.

---
 rtl/instruction_fetch_pkg.sv | 24 ++
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared opcodes, fetch state encoding and widths for the fetch stage
package instruction_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int unsigned PC_INC = 4;

    localparam logic [4:0] OP_CALL = 5'b10000;
    localparam logic [4:0] OP_B    = 5'b10001;
    localparam logic [4:0] OP_BEQ  = 5'b10010;
    localparam logic [4:0] OP_BGT  = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // True when the word carries the hlt opcode in its top five bits.
    function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1:INSTR_W-5] == OP_HLT;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, imem word reads, valid/ready hand-off to decode (hlt stop under FETCH_HALT_EN)
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic              kill;
    logic [ADDR_W-1:0] fetch_next;
    logic [ADDR_W-1:0] redirect_aligned;

    // Sequential address wraps naturally at 2^ADDR_W.
    assign fetch_next       = fetch_pc + ADDR_W'(PC_INC);
    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

`ifndef FETCH_HALT_EN
    assign halted = 1'b0;
`endif

    // Fetch FSM and datapath; imem_addr only moves when no request is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            kill        <= 1'b0;
            instruction <= '0;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
`ifdef FETCH_HALT_EN
            halted      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                    if (redirect_valid) begin
                        fetch_pc  <= redirect_aligned;
                        imem_addr <= redirect_aligned;
                    end else begin
                        imem_addr <= fetch_pc;
                    end
                end

                ST_FETCH: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            // Response belongs to the stale stream; reissue at the target.
                            fetch_pc  <= redirect_aligned;
                            imem_addr <= redirect_aligned;
                            kill      <= 1'b0;
                        end else if (kill) begin
                            // Drain of the request that was outstanding at redirect time.
                            kill      <= 1'b0;
                            imem_addr <= fetch_pc;
                        end else begin
                            instruction <= imem_rdata;
                            pc          <= fetch_pc;
                            fetch_pc    <= fetch_next;
                            imem_addr   <= fetch_next;
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= ST_HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Request stays up at its old address; its data is dropped on ack.
                        fetch_pc <= redirect_aligned;
                        kill     <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (redirect_valid) begin
                        fetch_pc    <= redirect_aligned;
                        imem_addr   <= redirect_aligned;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                        state       <= ST_FETCH;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
`ifdef FETCH_HALT_EN
                        if (is_hlt(instruction)) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= fetch_pc;
                            state     <= ST_FETCH;
                        end
`else
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        state     <= ST_FETCH;
`endif
                    end
                end

`ifdef FETCH_HALT_EN
                ST_HALT: begin
                    if (redirect_valid) begin
                        halted    <= 1'b0;
                        fetch_pc  <= redirect_aligned;
                        imem_addr <= redirect_aligned;
                        imem_req  <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
`endif

                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    kill        <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int tests = 0;
    int fails = 0;

    int          mem_lat  = 0;
    int          wait_cnt = 0;
    bit          rand_lat = 1'b0;
    bit          hlt_on   = 1'b0;
    logic [31:0] hlt_addr = 32'h80;

    instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instruction    (instruction),
        .pc             (pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Memory contents: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (hlt_on && a == hlt_addr) return 32'hF800_0000;
        return {1'b0, a[30:0] ^ 31'h5A5A_1234};
    endfunction

    // Advance one edge, then answer the request visible in this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (imem_req) begin
            if (wait_cnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
                if (rand_lat) mem_lat = $urandom_range(0, 3);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_cnt   = 0;
        end
    endtask

    task automatic apply_reset();
        rst            = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        wait_cnt       = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; wait_cnt = 0;
        @(posedge clk); #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %0b want 0", imem_req); end
        tests++; if (imem_addr !== RESET_PC) begin fails++; $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
        tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", instruction); end
        tests++; if (pc !== RESET_PC) begin fails++; $display("FAIL reset_pc got %h want %h", pc, RESET_PC); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %0b want 0", halted); end
        rst = 1'b1;
        tick();
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL first_req got %0b want 1", imem_req); end
        tests++; if (imem_addr !== RESET_PC) begin fails++; $display("FAIL first_addr got %h want %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp;
        int n, last;
        apply_reset();
        mem_lat = 0; instr_ready = 1'b1;
        exp = RESET_PC; n = 0; last = -1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            if (imem_req) begin
                tests++; if (imem_addr[1:0] !== 2'b00) begin fails++; $display("FAIL zw_align got %h want low bits 0", imem_addr); end
            end
            if (instr_valid) begin
                tests++; if (pc !== exp) begin fails++; $display("FAIL zw_pc got %h want %h", pc, exp); end
                tests++; if (instruction !== mem_word(exp)) begin fails++; $display("FAIL zw_instr got %h want %h", instruction, mem_word(exp)); end
                if (last >= 0) begin
                    tests++; if (c - last !== 2) begin fails++; $display("FAIL zw_rate got %0d want 2 cycles", c - last); end
                end
                last = c; exp = exp + 4; n++;
            end
        end
        tests++; if (n != 4) begin fails++; $display("FAIL zw_timeout got %0d deliveries want 4", n); end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        bit new_seen, done;
        apply_reset();
        mem_lat = 3; instr_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0101;
        tick();
        redirect_valid = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL rw_hold got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
        new_seen = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            tick();
            if (!new_seen && imem_req && imem_addr !== 32'h0) begin
                tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL rw_newaddr got %h want 100", imem_addr); end
                new_seen = 1;
            end
            if (instr_valid) begin
                tests++; if (pc !== 32'h100) begin fails++; $display("FAIL rw_pc got %h want 100", pc); end
                tests++; if (instruction !== mem_word(32'h100)) begin fails++; $display("FAIL rw_instr got %h want %h", instruction, mem_word(32'h100)); end
                done = 1;
            end
        end
        tests++; if (!done) begin fails++; $display("FAIL rw_timeout got no delivery want pc 100"); end
        instr_ready = 1'b0; mem_lat = 0;
    endtask

    task automatic test_hold_stall();
        apply_reset();
        mem_lat = 0; instr_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++; if (instr_valid !== 1'b1 || pc !== 32'h0 || instruction !== mem_word(32'h0) || imem_req !== 1'b0) begin
                fails++; $display("FAIL hold_stable got v=%0b pc=%h ins=%h req=%0b want 1/0/%h/0", instr_valid, pc, instruction, mem_word(32'h0), imem_req);
            end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL hold_drop got valid=%0b want 0", instr_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin fails++; $display("FAIL hold_refetch got req=%0b addr=%h want 1/40", imem_req, imem_addr); end
        instr_ready = 1'b1;
        tick();
        tests++; if (instr_valid !== 1'b1 || pc !== 32'h40) begin fails++; $display("FAIL hold_deliver got v=%0b pc=%h want 1/40", instr_valid, pc); end
        instr_ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        mem_lat = 0; instr_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            fails++; $display("FAIL sc_ackdrop got v=%0b req=%0b addr=%h want 0/1/200", instr_valid, imem_req, imem_addr);
        end
        tick();
        tests++; if (instr_valid !== 1'b1 || pc !== 32'h200) begin fails++; $display("FAIL sc_deliver got v=%0b pc=%h want 1/200", instr_valid, pc); end
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b0;
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            fails++; $display("FAIL sc_readyredir got v=%0b req=%0b addr=%h want 0/1/300", instr_valid, imem_req, imem_addr);
        end
        tick();
        tests++; if (instr_valid !== 1'b1 || pc !== 32'h300) begin fails++; $display("FAIL sc_deliver2 got v=%0b pc=%h want 1/300", instr_valid, pc); end
    endtask

    task automatic test_wrap_and_async_reset();
        apply_reset();
        mem_lat = 0; instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_start got req=%0b addr=%h want 1/fffffffc", imem_req, imem_addr); end
        tick();
        tests++; if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top got v=%0b pc=%h want 1/fffffffc", instr_valid, pc); end
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
        tick();
        tests++; if (instr_valid !== 1'b1 || pc !== 32'h0) begin fails++; $display("FAIL wrap_pc got v=%0b pc=%h want 1/0", instr_valid, pc); end
        mem_lat = 5;
        tick();
        #2;
        rst = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 || instruction !== 32'h0 || pc !== RESET_PC || halted !== 1'b0) begin
            fails++; $display("FAIL async_rst got req=%0b addr=%h v=%0b ins=%h pc=%h h=%0b want reset values", imem_req, imem_addr, instr_valid, instruction, pc, halted);
        end
        @(posedge clk); #1;
        rst = 1'b1; wait_cnt = 0;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        tests++; if (instr_valid !== 1'b0 || instruction !== 32'h0 || imem_addr !== RESET_PC) begin
            fails++; $display("FAIL late_ack got v=%0b ins=%h addr=%h want 0/0/%h", instr_valid, instruction, imem_addr, RESET_PC);
        end
        mem_lat = 0; instr_ready = 1'b0;
    endtask

    task automatic test_halt();
        apply_reset();
        hlt_on = 1'b1; hlt_addr = 32'h80;
        mem_lat = 0; instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        tick();
        tests++; if (instr_valid !== 1'b1 || pc !== 32'h80 || instruction !== 32'hF800_0000) begin
            fails++; $display("FAIL hlt_deliver got v=%0b pc=%h ins=%h want 1/80/f8000000", instr_valid, pc, instruction);
        end
        tick();
`ifdef FETCH_HALT_EN
        tests++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL hlt_stop got h=%0b req=%0b v=%0b want 1/0/0", halted, imem_req, instr_valid);
        end
        repeat (3) tick();
        tests++; if (halted !== 1'b1 || imem_req !== 1'b0) begin fails++; $display("FAIL hlt_stay got h=%0b req=%0b want 1/0", halted, imem_req); end
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        tests++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            fails++; $display("FAIL hlt_resume got h=%0b req=%0b addr=%h want 0/1/20", halted, imem_req, imem_addr);
        end
`else
        tests++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h84) begin
            fails++; $display("FAIL hlt_plain got h=%0b req=%0b addr=%h want 0/1/84", halted, imem_req, imem_addr);
        end
`endif
        hlt_on = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp, prev_addr;
        logic        prev_req, prev_ack;
        int          xfers;
        apply_reset();
        rand_lat = 1'b1; mem_lat = $urandom_range(0, 3);
        exp = RESET_PC; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; xfers = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            redirect_valid = 1'b0;
            if (prev_req && !prev_ack) begin
                tests++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    fails++; $display("FAIL rnd_reqhold got req=%0b addr=%h want 1/%h", imem_req, imem_addr, prev_addr);
                end
            end
            if (imem_req) begin
                tests++; if (imem_addr[1:0] !== 2'b00) begin fails++; $display("FAIL rnd_align got %h want low bits 0", imem_addr); end
            end
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom_range(0, 1023);
            if (instr_valid && instr_ready) begin
                tests++; if (pc !== exp) begin fails++; $display("FAIL rnd_pc got %h want %h", pc, exp); end
                tests++; if (instruction !== mem_word(exp)) begin fails++; $display("FAIL rnd_instr got %h want %h", instruction, mem_word(exp)); end
                exp = exp + 4;
                xfers++;
            end
            if (redirect_valid) exp = redirect_pc & ~32'h3;
            prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
        end
        redirect_valid = 1'b0; instr_ready = 1'b0; rand_lat = 1'b0;
        tests++; if (xfers < 20) begin fails++; $display("FAIL rnd_progress got %0d transfers want at least 20", xfers); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_redirect_wait();
        test_hold_stall();
        test_same_cycle();
        test_wrap_and_async_reset();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
